// File: rtl/inst_buffer_queue_pkg.sv
// Types and sizing shared by the instruction buffer between Decode and Rename.
// renPkt is the per-lane payload; valid marks a live lane in a decode bundle.
package inst_buffer_queue_pkg;

   localparam int DISPATCH_WIDTH = 4;
   localparam int IB_DEPTH       = 32;
   localparam int SIZE_IB_LOG    = $clog2(IB_DEPTH);

   // Offset of a lane within the compacted bundle, and a lane count 0..DISPATCH_WIDTH.
   localparam int LANE_OFF_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;
   localparam int LANE_CNT_W = $clog2(DISPATCH_WIDTH + 1);

   typedef struct packed {
      logic        valid;
      logic [15:0] seqNo;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  archDest;
   } renPkt;

endpackage

// File: rtl/inst_buffer_queue_lane_compact.sv
// Prefix popcount over lane valids: each valid lane learns how many valid lanes
// precede it, which is its slot offset from the tail when the bundle is packed.
module ib_lane_compact
   import inst_buffer_queue_pkg::*;
(
   input  logic [DISPATCH_WIDTH-1:0]                 laneValid,
   output logic [DISPATCH_WIDTH-1:0][LANE_OFF_W-1:0] laneOffset,
   output logic [LANE_CNT_W-1:0]                     nWr
);

   logic [LANE_CNT_W-1:0] runCount;

   always_comb begin
      runCount   = '0;
      laneOffset = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         laneOffset[i] = runCount[LANE_OFF_W-1:0];
         runCount      = runCount + LANE_CNT_W'(laneValid[i]);
      end
      nWr = runCount;
   end

endmodule

// File: rtl/inst_buffer_queue.sv
// Circular instruction buffer: packs the valid lanes of each decode bundle in
// program order and hands Rename full DISPATCH_WIDTH bundles, oldest in lane 0.
module inst_buffer_queue
   import inst_buffer_queue_pkg::*;
#(
   parameter int DEPTH = IB_DEPTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush_i,
   input  logic                              decodeReady_i,
   input  renPkt [DISPATCH_WIDTH-1:0]        ibPacket_i,
   input  logic                              stall_i,
   output renPkt [DISPATCH_WIDTH-1:0]        ibPacket_o,
   output logic                              instBufferReady_o,
   output logic                              stallFetch_o,
   output logic [$clog2(DEPTH):0]            ibCount_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] headPtr;
   logic [PTR_W-1:0] tailPtr;
   logic [PTR_W:0]   count;
   renPkt            storage [DEPTH];

   logic [DISPATCH_WIDTH-1:0]                 laneValid;
   logic [DISPATCH_WIDTH-1:0][LANE_OFF_W-1:0] laneOffset;
   logic [LANE_CNT_W-1:0]                     nWr;
   logic [LANE_CNT_W-1:0]                     nWrEff;
   logic [PTR_W:0]                            nRd;
   logic                                      writeEn;
   logic                                      readFire;

   genvar gi;
   generate
      for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : gLaneValid
         assign laneValid[gi] = ibPacket_i[gi].valid;
      end
   endgenerate

   ib_lane_compact uCompact (
      .laneValid  (laneValid),
      .laneOffset (laneOffset),
      .nWr        (nWr)
   );

   // Both handshakes derive from occupancy alone, so stale storage is never exposed.
   assign stallFetch_o      = (DEPTH - int'(count)) < DISPATCH_WIDTH;
   assign instBufferReady_o = (int'(count) >= DISPATCH_WIDTH) && !flush_i;
   assign ibCount_o         = count;

   assign writeEn  = decodeReady_i && !stallFetch_o && !flush_i;
   assign readFire = instBufferReady_o && !stall_i;
   assign nWrEff   = writeEn ? nWr : '0;
   assign nRd      = readFire ? (PTR_W+1)'(DISPATCH_WIDTH) : '0;

   always_comb begin
      ibPacket_o = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         ibPacket_o[i]       = storage[headPtr + PTR_W'(i)];
         ibPacket_o[i].valid = instBufferReady_o;
      end
   end

   // Payload storage carries no reset; occupancy gates everything read from it.
   always_ff @(posedge clk) begin
      if (writeEn) begin
         for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (laneValid[i]) begin
               storage[tailPtr + PTR_W'(laneOffset[i])] <= ibPacket_i[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else if (flush_i) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (readFire) begin
            headPtr <= headPtr + PTR_W'(DISPATCH_WIDTH);
         end
         tailPtr <= tailPtr + PTR_W'(nWrEff);
         count   <= count + (PTR_W+1)'(nWrEff) - nRd;
      end
   end

endmodule
